// File: rtl/spi_master_pkg.sv
// Shared types and constants for the single-byte SPI mode-0 master.
package spi_master_pkg;

  // Bits per transfer and the width of the falling-edge counter.
  localparam int SPI_BITS  = 8;
  localparam int BIT_CNT_W = $clog2(SPI_BITS);

  // Transfer sequencing: chip-select lead, eight SCK periods, chip-select
  // trail, then a single completion cycle.
  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_LEAD  = 3'd1,
    ST_SHIFT = 3'd2,
    ST_TRAIL = 3'd3,
    ST_DONE  = 3'd4
  } state_e;

endpackage

// File: rtl/spi_clk_div.sv
// Half-period tick generator for SCK. tick_o pulses once every CLK_DIV enabled
// cycles. restart_i reloads the counter so the very next enabled cycle ticks,
// which lets the master align the first SCK rise right after chip-select lead.
module spi_clk_div #(
  parameter int CLK_DIV = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en_i,
  input  logic restart_i,
  output logic tick_o
);

  localparam int CNT_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLK_DIV - 1);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  assign tick_o = en_i && (cnt_q == CNT_LAST);

  // Next count: held at zero while disabled, wraps on every tick.
  always_comb begin
    cnt_d = cnt_q;
    if (!en_i) begin
      cnt_d = '0;
    end else if (restart_i) begin
      cnt_d = CNT_LAST;
    end else if (tick_o) begin
      cnt_d = '0;
    end else begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  // Counter register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/spi_master.sv
// Single-byte SPI master, mode 0 (CPOL=0, CPHA=0), MSB first, one chip select.
// Optional watchdog compiled in with SPI_MASTER_WATCHDOG_EN: aborts a transfer
// that stays busy for WDT_CYCLES clocks and pulses error_o instead of done_o.
//
// Controller handshake: start_i is sampled only while idle; a high sample
// latches data_i and begins a transfer. Exactly one of done_o (with data_o
// valid in the same cycle) or error_o pulses for one cycle per accepted
// transfer. start_i is ignored while busy; nothing is queued.
//
// MISO uses a late-sample scheme: samples are taken at SCK rises 2..8 and at
// the end of the trail phase, matching a slave that launches each bit on the
// preceding falling SCK edge.
module spi_master
  import spi_master_pkg::*;
#(
  parameter int CLK_DIV    = 4,
  parameter int WDT_CYCLES = 1024
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start_i,
  input  logic [7:0] data_i,
  output logic [7:0] data_o,
  output logic       done_o,
  output logic       error_o,
  output logic       sck_o,
  output logic       mosi_o,
  input  logic       miso_i,
  output logic       cs_n_o
);

  localparam logic [BIT_CNT_W-1:0] LAST_BIT = BIT_CNT_W'(SPI_BITS - 1);

  // Reject divider or watchdog settings that cannot produce a working bus.
  if (CLK_DIV < 1 || WDT_CYCLES < 2) begin : g_param_check
    $error("spi_master: CLK_DIV must be >= 1 and WDT_CYCLES >= 2");
  end

  state_e                state_q;
  logic                  cs_n_q;
  logic                  sck_q;
  logic                  mosi_q;
  logic                  done_q;
  logic                  error_q;
  logic [SPI_BITS-1:0]   data_q;
  logic [SPI_BITS-2:0]   tx_q;      // bits still to be launched after the MSB
  logic [SPI_BITS-2:0]   rx_q;      // first seven received bits
  logic [BIT_CNT_W-1:0]  bit_cnt_q; // falling SCK edges seen so far
  logic                  tick;
  logic                  div_en;
  logic                  div_restart;
  logic                  wdt_expire;

  // The divider runs through lead, shift and trail; it is re-primed when lead
  // ends so the first SCK rise follows one cycle later.
  assign div_en      = (state_q == ST_LEAD) || (state_q == ST_SHIFT) ||
                       (state_q == ST_TRAIL);
  assign div_restart = (state_q == ST_LEAD) && tick;

  spi_clk_div #(
    .CLK_DIV (CLK_DIV)
  ) u_clk_div (
    .clk       (clk),
    .rst_n     (rst_n),
    .en_i      (div_en),
    .restart_i (div_restart),
    .tick_o    (tick)
  );

`ifdef SPI_MASTER_WATCHDOG_EN
  localparam int WDT_W = $clog2(WDT_CYCLES + 1);
  localparam logic [WDT_W-1:0] WDT_LAST = WDT_W'(WDT_CYCLES - 1);

  logic [WDT_W-1:0] wdt_q;

  // Busy-time counter; cleared whenever the master is idle or has aborted.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wdt_q <= '0;
    end else if (state_q == ST_IDLE || wdt_expire) begin
      wdt_q <= '0;
    end else begin
      wdt_q <= wdt_q + 1'b1;
    end
  end

  // A transfer already in its completion cycle is allowed to finish.
  assign wdt_expire = div_en && (wdt_q == WDT_LAST);
`else
  assign wdt_expire = 1'b0;
`endif

  // Transfer FSM with registered bus and handshake outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      cs_n_q    <= 1'b1;
      sck_q     <= 1'b0;
      mosi_q    <= 1'b0;
      done_q    <= 1'b0;
      error_q   <= 1'b0;
      data_q    <= '0;
      tx_q      <= '0;
      rx_q      <= '0;
      bit_cnt_q <= '0;
    end else begin
      done_q  <= 1'b0;
      error_q <= 1'b0;
      if (wdt_expire) begin
        state_q <= ST_IDLE;
        cs_n_q  <= 1'b1;
        sck_q   <= 1'b0;
        mosi_q  <= 1'b0;
        error_q <= 1'b1;
      end else begin
        case (state_q)
          ST_IDLE: begin
            if (start_i) begin
              state_q   <= ST_LEAD;
              cs_n_q    <= 1'b0;
              mosi_q    <= data_i[SPI_BITS-1];
              tx_q      <= data_i[SPI_BITS-2:0];
              rx_q      <= '0;
              bit_cnt_q <= '0;
            end
          end
          ST_LEAD: begin
            if (tick) begin
              state_q <= ST_SHIFT;
            end
          end
          ST_SHIFT: begin
            if (tick) begin
              if (!sck_q) begin
                // Rising edge: the first rise carries no valid MISO bit yet.
                sck_q <= 1'b1;
                if (bit_cnt_q != '0) begin
                  rx_q <= {rx_q[SPI_BITS-3:0], miso_i};
                end
              end else begin
                // Falling edge: launch the next MOSI bit, or finish shifting.
                sck_q <= 1'b0;
                if (bit_cnt_q == LAST_BIT) begin
                  state_q <= ST_TRAIL;
                end else begin
                  bit_cnt_q <= bit_cnt_q + 1'b1;
                  mosi_q    <= tx_q[SPI_BITS-2];
                  tx_q      <= {tx_q[SPI_BITS-3:0], 1'b0};
                end
              end
            end
          end
          ST_TRAIL: begin
            if (tick) begin
              // Final late sample completes the byte.
              state_q <= ST_DONE;
              data_q  <= {rx_q, miso_i};
              done_q  <= 1'b1;
              cs_n_q  <= 1'b1;
              mosi_q  <= 1'b0;
            end
          end
          ST_DONE: begin
            state_q <= ST_IDLE;
          end
          default: begin
            state_q <= ST_IDLE;
          end
        endcase
      end
    end
  end

  assign cs_n_o  = cs_n_q;
  assign sck_o   = sck_q;
  assign mosi_o  = mosi_q;
  assign done_o  = done_q;
  assign error_o = error_q;
  assign data_o  = data_q;

endmodule

// File: tb/tb_spi_master.sv
// Directed and randomized bench for spi_master. A behavioural mode-0 slave
// launches its response MSB first on each falling SCK edge and captures MOSI
// on rising edges; expected data and timing come from the bus rules.
module tb_spi_master;

  localparam int CD = 3;
`ifdef SPI_MASTER_WATCHDOG_EN
  localparam int WDT = 40;
`else
  localparam int WDT = 1024;
`endif
  localparam int XFER_LAT = 1 + 17 * CD;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start_i;
  logic [7:0] data_i;
  logic [7:0] data_o;
  logic       done_o;
  logic       error_o;
  logic       sck_o;
  logic       mosi_o;
  logic       miso_i = 1'b0;
  logic       cs_n_o;

  int tests = 0;
  int fails = 0;
  int cyc   = 0;

  // Slave / bus monitor state.
  logic [7:0] slv_resp = 8'h00;
  logic [7:0] cap = 8'h00;
  bit   prev_sck = 1'b0;
  bit   prev_cs  = 1'b1;
  bit   have_chg = 1'b0;
  int   rises = 0;
  int   falls = 0;
  int   phase_bad = 0;
  int   first_rise = 0;
  int   last_chg = 0;

  spi_master #(
    .CLK_DIV    (CD),
    .WDT_CYCLES (WDT)
  ) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .start_i (start_i),
    .data_i  (data_i),
    .data_o  (data_o),
    .done_o  (done_o),
    .error_o (error_o),
    .sck_o   (sck_o),
    .mosi_o  (mosi_o),
    .miso_i  (miso_i),
    .cs_n_o  (cs_n_o)
  );

  // Clock and edge counter.
  always #5 clk = ~clk;
  always @(posedge clk) cyc = cyc + 1;

  // Mode-0 slave and SCK timing monitor, sampled mid-cycle.
  always @(negedge clk) begin
    if (cs_n_o === 1'b0 && prev_cs) begin
      rises = 0; falls = 0; cap = 8'h00; have_chg = 1'b0;
      phase_bad = 0; first_rise = 0; miso_i = 1'b0;
    end
    if (sck_o !== prev_sck) begin
      if (have_chg && (cyc - last_chg) != CD) phase_bad = phase_bad + 1;
      if (sck_o === 1'b1) begin
        if (rises == 0) first_rise = cyc;
        rises = rises + 1;
        cap = {cap[6:0], mosi_o};
      end else begin
        falls = falls + 1;
        if (falls >= 1 && falls <= 8) miso_i = slv_resp[8 - falls];
      end
      have_chg = 1'b1;
      last_chg = cyc;
    end
    prev_sck = (sck_o === 1'b1);
    prev_cs  = (cs_n_o !== 1'b0);
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests = tests + 1;
    assert (obs === exp) else begin
      fails = fails + 1;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

`ifndef SPI_MASTER_WATCHDOG_EN
  // One full transfer starting at the current negedge; optionally pokes
  // start_i mid-transfer, which must have no effect.
  task automatic do_xfer(input logic [7:0] tx, input logic [7:0] resp, input bit poke);
    int e0;
    int n;
    int cs_bad;
    slv_resp = resp;
    data_i   = tx;
    start_i  = 1'b1;
    e0 = cyc + 1;
    @(negedge clk);
    start_i = 1'b0;
    data_i  = 8'($urandom);
    check("cs_low_lead", cs_n_o, 0);
    n = 0;
    cs_bad = 0;
    while (done_o !== 1'b1 && n < 300) begin
      if (cs_n_o !== 1'b0) cs_bad = cs_bad + 1;
      start_i = (poke && n == 20);
      if (poke && n == 20) data_i = ~tx;
      @(negedge clk);
      n = n + 1;
    end
    start_i = 1'b0;
    check("done_pulse", done_o, 1);
    check("done_latency", cyc - e0, XFER_LAT);
    check("rx_byte", data_o, resp);
    check("no_error", error_o, 0);
    check("cs_low_busy", cs_bad, 0);
    check("cs_high_done", cs_n_o, 1);
    check("slave_rx", cap, tx);
    check("sck_rises", rises, 8);
    check("sck_phase", phase_bad, 0);
    check("first_rise", first_rise - e0, 1 + CD);
    @(negedge clk);
    check("done_one_cycle", done_o, 0);
    check("cs_high_after", cs_n_o, 1);
    check("rx_held", data_o, resp);
  endtask
`else
  // Transfer that must be cut short by the watchdog.
  task automatic wdt_xfer(input logic [7:0] tx, input logic [7:0] resp);
    int e0;
    int n;
    bit saw_done;
    slv_resp = resp;
    data_i   = tx;
    start_i  = 1'b1;
    e0 = cyc + 1;
    @(negedge clk);
    start_i = 1'b0;
    n = 0;
    saw_done = 1'b0;
    while (error_o !== 1'b1 && n < 300) begin
      if (done_o === 1'b1) saw_done = 1'b1;
      @(negedge clk);
      n = n + 1;
    end
    check("wdt_error", error_o, 1);
    check("wdt_latency", cyc - e0, WDT);
    check("wdt_no_done", {saw_done, done_o}, 0);
    check("wdt_cs_high", cs_n_o, 1);
    check("wdt_sck_low", sck_o, 0);
    check("wdt_data_kept", data_o, 0);
    @(negedge clk);
    check("wdt_err_one_cycle", error_o, 0);
  endtask
`endif

  initial begin
    rst_n   = 1'b0;
    start_i = 1'b0;
    data_i  = 8'h00;
    repeat (3) @(negedge clk);
    check("rst_cs", cs_n_o, 1);
    check("rst_sck", sck_o, 0);
    check("rst_mosi", mosi_o, 0);
    check("rst_done", done_o, 0);
    check("rst_error", error_o, 0);
    check("rst_data", data_o, 0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    check("idle_cs", cs_n_o, 1);
    check("idle_sck", sck_o, 0);

`ifndef SPI_MASTER_WATCHDOG_EN
    do_xfer(8'hA5, 8'h3C, 1'b0);
    do_xfer(8'h00, 8'hFF, 1'b0);
    do_xfer(8'hFF, 8'h55, 1'b0);
    for (int i = 0; i < 8; i++) begin
      logic [7:0] w;
      w = 8'(1 << i);
      do_xfer(w, ~w, 1'b0);
    end
    // Back-to-back at the earliest accept, with a spurious mid-transfer start.
    do_xfer(8'h11, 8'hAA, 1'b0);
    do_xfer(8'h22, 8'h55, 1'b1);
    do_xfer(8'h33, 8'hCC, 1'b0);
    repeat (2) @(negedge clk);
    check("no_queued_xfer", cs_n_o, 1);
    for (int i = 0; i < 6; i++) begin
      do_xfer(8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)), 1'($urandom_range(0, 1)));
    end
    do_xfer(8'h96, 8'h5A, 1'b0);
`else
    wdt_xfer(8'hA5, 8'h3C);
    repeat (2) @(negedge clk);
    wdt_xfer(8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)));
`endif

    // Asynchronous reset in the middle of a transfer.
    slv_resp = 8'hE7;
    data_i   = 8'hC3;
    start_i  = 1'b1;
    @(negedge clk);
    start_i = 1'b0;
    repeat (25) @(negedge clk);
    check("mid_cs_low", cs_n_o, 0);
    #2 rst_n = 1'b0;
    #1;
    check("arst_cs", cs_n_o, 1);
    check("arst_sck", sck_o, 0);
    check("arst_mosi", mosi_o, 0);
    check("arst_done", done_o, 0);
    check("arst_error", error_o, 0);
    check("arst_data", data_o, 0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    check("post_rst_cs", cs_n_o, 1);
    check("post_rst_done", done_o, 0);
`ifndef SPI_MASTER_WATCHDOG_EN
    do_xfer(8'h5C, 8'h81, 1'b0);
`else
    wdt_xfer(8'h5C, 8'h81);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/spi_master.md
# spi_master

Single-byte SPI bus master, mode 0 (CPOL=0, CPHA=0), MSB first, with one chip select. It sits between an on-chip controller issuing byte transfers through a start/done handshake and an external SPI slave. SCK is derived from the system clock by a programmable divider. An optional watchdog flags and aborts transfers that fail to complete.

## Interface
- `CLK_DIV`, default 4: system-clock cycles per SCK half-period; legal range ≥1.
- `WDT_CYCLES`, default 1024: watchdog limit in system clocks. Used only when the watchdog is compiled in. Must exceed `17*CLK_DIV+4`.
- `clk` in 1: system clock; all logic on its rising edge.
- `rst_n` in 1: reset, asynchronous and active-low.
- `start_i` in 1: transfer request; sampled only in IDLE.
- `data_i` in 8: transmit byte; latched in the cycle `start_i` is accepted.
- `data_o` out 8: received byte; updated only on successful completion, held until the next completion.
- `done_o` out 1: one-cycle completion pulse.
- `error_o` out 1: one-cycle watchdog-abort pulse.
- `sck_o` out 1: SPI clock, idles low.
- `mosi_o` out 1: serial data out.
- `miso_i` in 1: serial data in.
- `cs_n_o` out 1: chip select, active low, idles high.

## Operation
- Reset values: `cs_n_o`=1, `sck_o`=0, `mosi_o`=0, `done_o`=0, `error_o`=0, `data_o`=8'h00, state IDLE.
- States and transitions:
  - IDLE → LEAD on `start_i`=1.
  - LEAD → SHIFT after `CLK_DIV` cycles.
  - SHIFT → TRAIL after the 8th falling SCK edge.
  - TRAIL → DONE after `CLK_DIV` cycles.
  - DONE → IDLE after one cycle.
- Latching on accept: `data_i` is copied to the TX shift register, and the RX register and bit counter are cleared.
- LEAD: `cs_n_o`=0, `mosi_o`=`data_i[7]`, `sck_o` stays low.
- SHIFT: `sck_o` toggles every `CLK_DIV` cycles, giving exactly 8 rising and 8 falling edges.
  - Rising edge k: the slave samples MOSI.
  - Falling edge k, for k<8: `mosi_o` advances to bit 7−k.
- MISO sampling uses a late-sample scheme:
  - `miso_i` is sampled at rising edges 2..8 and at the end of TRAIL, giving 8 samples shifted in MSB first.
  - This matches a slave that drives each MISO bit on the preceding falling SCK edge.
- DONE:
  - `data_o` loads the RX register, `done_o`=1, `cs_n_o`=1, `sck_o`=0.
  - `data_o` and `done_o` are valid in the same cycle.
- `start_i` outside IDLE is ignored. No queuing; a back-to-back request must be reissued after `done_o`.
- Reset asserted mid-transfer: immediate return to reset values, `cs_n_o` high. `data_o` is cleared, not updated with the partial byte.

## Timing
- Cycle-level sequence, with `start_i` sampled high at edge 0:
  - `cs_n_o` falls after edge 0.
  - First SCK rise at edge `1+CLK_DIV`.
  - SCK period is `2*CLK_DIV` cycles.
  - `done_o` is high in the cycle after `1+17*CLK_DIV` edges: 69 cycles for `CLK_DIV`=4.
- CS setup: ≥`CLK_DIV` clocks before the first SCK rise. CS hold: `CLK_DIV` clocks after the last SCK fall.
- `cs_n_o` is high from the `done_o` cycle onward.
- Earliest next accept: the cycle after `done_o`.

## Configuration
- `SPI_MASTER_WATCHDOG_EN` defined:
  - A counter runs while not IDLE.
  - On reaching `WDT_CYCLES`: abort to IDLE, `cs_n_o`=1, `sck_o`=0, `error_o` one-cycle pulse.
  - No `done_o` for that transfer; `data_o` is unchanged.
- Undefined: no counter; `error_o` is tied 0.
- `done_o` and `error_o` are never high in the same cycle.

## Structure
- `spi_master_pkg`:
  - state enum (IDLE, LEAD, SHIFT, TRAIL, DONE)
  - `SPI_BITS`=8
  - bit-counter width constant
- Sub-module `spi_clk_div`: `CLK_DIV`-cycle half-period tick generator with enable and restart. The FSM and shift registers remain in `spi_master`.

## Test plan
- Idle after reset:
  - `cs_n_o`=1, `sck_o`=0, `done_o`=0, `error_o`=0.
  - After accept, `cs_n_o`=0 from the first LEAD cycle through TRAIL.
- TX 8'hA5, mode-0 slave returning 8'h3C:
  - slave captures 8'hA5 on rising edges
  - `data_o`=8'h3C with `done_o` pulse, no error
  - `cs_n_o`=1 two cycles later
- TX 8'h00/8'hFF with slave 8'hFF/8'h55:
  - exact RX match
  - exactly 8 SCK rising edges per transfer, each SCK phase `CLK_DIV` clocks
- Walking ones, TX=1<<i for i=0..7, slave returns ~TX: each RX equals ~TX.
- Back-to-back transfers with three slave responses:
  - TX 8'h11 with slave 8'hAA → `data_o`=8'hAA
  - TX 8'h22 with slave 8'h55 → `data_o`=8'h55
  - TX 8'h33 with slave 8'hCC → `data_o`=8'hCC
  - `start_i` pulsed mid-transfer is ignored.
- With `SPI_MASTER_WATCHDOG_EN` and `WDT_CYCLES` < transfer length:
  - `error_o` pulse, no `done_o`, `cs_n_o`=1, `data_o` unchanged
  - Async `rst_n` mid-transfer returns all outputs to reset values.
